pipeline_stall_controller: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipeline_stall_controller.sv | 203 ++++++++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller
//
// Central stall/flush sequencer for a 5-stage IF/ID/EX/MEM/WB pipeline.
// Hazard sources are handled in this order of precedence:
//   1. data-memory wait state (MEM-stage access not ready)
//   2. multi-cycle mul/div unit busy
//   3. taken branch/jump in EX
//   4. load-use hazard in ID
// A lower-priority request is masked while a higher one is active. Masked
// requests are not remembered: they are evaluated again on the next cycle.
// The block also keeps a saturating count of cycles in which the PC is held.
//
// Parameters
//   MEM_TIMEOUT  maximum consecutive memory-stall cycles before abort (>= 2)
//   CNT_W        width of the stall_cycles performance counter
//
// Ports
//   clk, rst_n          clock (rising edge); synchronous active-low reset
//   load_use_id         load-use hazard for the instruction in ID
//   branch_tkn_ex       branch/jump taken in EX
//   dmem_req_mem        MEM-stage instruction accesses data memory
//   dmem_ready          data memory completes its access this cycle
//   md_start_ex         mul/div instruction in EX is starting
//   md_done             mul/div result valid this cycle
//   perf_clr            clear stall_cycles
//   pc_we               PC write enable
//   hold_*              pipeline register holds its contents
//   flush_*             pipeline register loads a NOP
//   mem_timeout         one-cycle pulse when a memory access is aborted
//   state_o             FSM state (RUN=0, MEM_WAIT=1, MD_BUSY=2)
//   stall_cycles        saturating count of cycles with pc_we=0
// -----------------------------------------------------------------------------
module pipeline_stall_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_id,
  input  logic             branch_tkn_ex,
  input  logic             dmem_req_mem,
  input  logic             dmem_ready,
  input  logic             md_start_ex,
  input  logic             md_done,
  input  logic             perf_clr,
  output logic             pc_we,
  output logic             hold_if_id,
  output logic             hold_id_ex,
  output logic             hold_ex_mem,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             flush_mem_wb,
  output logic             mem_timeout,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MD_BUSY  = 2'd2
  } state_t;

  localparam int             TW      = $clog2(MEM_TIMEOUT);
  localparam logic [TW-1:0]  TO_LAST = TW'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_r;
  logic [TW-1:0]    tmo_cnt_r;
  logic             md_done_seen_r;
  logic [CNT_W-1:0] stall_cnt_r;

  logic mem_stall_s;
  logic md_stall_s;
  logic timeout_hit_s;

  assign mem_stall_s = dmem_req_mem & ~dmem_ready;

  // Mul/div stall: while busy and no completion observed, or when a new
  // op starts in RUN and does not finish in the same cycle.
  assign md_stall_s = ((state_r == ST_MD_BUSY) & ~md_done & ~md_done_seen_r) |
                      ((state_r == ST_RUN) & md_start_ex & ~md_done);

  // The counter already includes the stall cycle that entered MEM_WAIT, so
  // hitting TO_LAST here marks the MEM_TIMEOUT-th consecutive stall cycle.
  assign timeout_hit_s = mem_stall_s & (state_r == ST_MEM_WAIT) & (tmo_cnt_r == TO_LAST);

  // Prioritised stall/flush decode from current state and hazard inputs.
  always_comb begin
    pc_we        = 1'b1;
    hold_if_id   = 1'b0;
    hold_id_ex   = 1'b0;
    hold_ex_mem  = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    flush_mem_wb = 1'b0;
    mem_timeout  = 1'b0;
    if (!rst_n) begin
      pc_we = 1'b1;
    end else if (mem_stall_s) begin
      // Freeze everything up to EX/MEM; WB receives a bubble.
      pc_we        = 1'b0;
      hold_if_id   = 1'b1;
      hold_id_ex   = 1'b1;
      hold_ex_mem  = 1'b1;
      flush_mem_wb = 1'b1;
      mem_timeout  = timeout_hit_s;
    end else if (md_stall_s) begin
      // Freeze front end; MEM receives a bubble while EX computes.
      pc_we        = 1'b0;
      hold_if_id   = 1'b1;
      hold_id_ex   = 1'b1;
      flush_ex_mem = 1'b1;
    end else if (branch_tkn_ex) begin
      // Squash the two wrong-path instructions; load-use is moot.
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
    end else if (load_use_id) begin
      pc_we        = 1'b0;
      hold_if_id   = 1'b1;
      flush_id_ex  = 1'b1;
    end else begin
      pc_we = 1'b1;
    end
  end

  // Sequencer state, memory-wait timeout counter and early-done flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= ST_RUN;
      tmo_cnt_r      <= '0;
      md_done_seen_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          md_done_seen_r <= 1'b0;
          if (mem_stall_s) begin
            state_r   <= ST_MEM_WAIT;
            tmo_cnt_r <= TW'(1);
          end else if (md_stall_s) begin
            state_r   <= ST_MD_BUSY;
            tmo_cnt_r <= '0;
          end else begin
            state_r   <= ST_RUN;
            tmo_cnt_r <= '0;
          end
        end
        ST_MEM_WAIT: begin
          md_done_seen_r <= 1'b0;
          if (timeout_hit_s) begin
            state_r   <= ST_RUN;
            tmo_cnt_r <= '0;
          end else if (mem_stall_s) begin
            state_r   <= ST_MEM_WAIT;
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
          end else begin
            state_r   <= ST_RUN;
            tmo_cnt_r <= '0;
          end
        end
        ST_MD_BUSY: begin
          tmo_cnt_r <= '0;
          if (mem_stall_s) begin
            // Remember a completion that arrives while memory is stalling.
            state_r        <= ST_MD_BUSY;
            md_done_seen_r <= md_done_seen_r | md_done;
          end else if (md_done || md_done_seen_r) begin
            state_r        <= ST_RUN;
            md_done_seen_r <= 1'b0;
          end else begin
            state_r        <= ST_MD_BUSY;
            md_done_seen_r <= md_done_seen_r;
          end
        end
        default: begin
          state_r        <= ST_RUN;
          tmo_cnt_r      <= '0;
          md_done_seen_r <= 1'b0;
        end
      endcase
    end
  end

  // Saturating performance counter of PC-hold cycles; clear wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_r <= '0;
    end else if (perf_clr) begin
      stall_cnt_r <= '0;
    end else if (!pc_we && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign state_o      = state_r;
  assign stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench: the stimulus process drives one cycle of hazard inputs,
// predicts the expected response from a behavioural model and queues it; a
// monitor on the falling edge pops each prediction and compares.
module tb_pipeline_stall_controller;

  localparam int MT = 16;
  localparam int CW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic load_use_id = 1'b0, branch_tkn_ex = 1'b0, dmem_req_mem = 1'b0;
  logic dmem_ready = 1'b1, md_start_ex = 1'b0, md_done = 1'b0, perf_clr = 1'b0;
  logic pc_we, hold_if_id, hold_id_ex, hold_ex_mem;
  logic flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb, mem_timeout;
  logic [1:0] state_o;
  logic [CW-1:0] stall_cycles;

  pipeline_stall_controller #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .load_use_id(load_use_id), .branch_tkn_ex(branch_tkn_ex),
    .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready), .md_start_ex(md_start_ex),
    .md_done(md_done), .perf_clr(perf_clr), .pc_we(pc_we), .hold_if_id(hold_if_id),
    .hold_id_ex(hold_id_ex), .hold_ex_mem(hold_ex_mem), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem), .flush_mem_wb(flush_mem_wb),
    .mem_timeout(mem_timeout), .state_o(state_o), .stall_cycles(stall_cycles)
  );

  typedef struct {
    logic [8:0]    ctl;   // pc_we,hold x3,flush x4,mem_timeout
    logic [1:0]    st;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: length of the current memory-stall episode, whether a
  // mul/div op is outstanding, whether it finished during a memory stall, and
  // the number of cycles the PC has been held.
  int m_mem_run = 0;
  bit m_md_busy = 1'b0;
  bit m_seen    = 1'b0;
  int m_cnt     = 0;

  task automatic step(input bit rn, input bit lu, input bit br, input bit req,
                      input bit rdy, input bit ms, input bit md, input bit pc);
    exp_t e;
    bit mem, mdst, tmo;
    logic [8:0] c;
    @(posedge clk);
    #1;
    rst_n = rn; load_use_id = lu; branch_tkn_ex = br; dmem_req_mem = req;
    dmem_ready = rdy; md_start_ex = ms; md_done = md; perf_clr = pc;

    e.st  = m_md_busy ? 2'd2 : ((m_mem_run > 0) ? 2'd1 : 2'd0);
    e.cnt = CW'(m_cnt);
    mem  = req && !rdy;
    if (m_md_busy)          mdst = !md && !m_seen;
    else if (m_mem_run == 0) mdst = ms && !md;
    else                    mdst = 1'b0;
    tmo  = mem && !m_md_busy && (m_mem_run == MT - 1);

    if (!rn)       c = 9'b1_000_0000_0;
    else if (mem)  c = {1'b0, 3'b111, 4'b0001, tmo};
    else if (mdst) c = 9'b0_110_0010_0;
    else if (br)   c = 9'b1_000_1100_0;
    else if (lu)   c = 9'b0_100_0100_0;
    else           c = 9'b1_000_0000_0;
    e.ctl = c;
    sbq.push_back(e);

    // Advance the model to the state seen after this clock edge.
    if (!rn) begin
      m_mem_run = 0; m_md_busy = 1'b0; m_seen = 1'b0; m_cnt = 0;
    end else begin
      if (m_md_busy) begin
        if (mem) m_seen = m_seen | md;
        else if (md || m_seen) begin m_md_busy = 1'b0; m_seen = 1'b0; end
      end else if (mem) begin
        m_mem_run = tmo ? 0 : m_mem_run + 1;
      end else if (m_mem_run > 0) begin
        m_mem_run = 0;
      end else if (mdst) begin
        m_md_busy = 1'b1;
      end
      if (pc) m_cnt = 0;
      else if (!c[8] && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 1, 0, 0, 0);
  endtask

  // Monitor: every cycle with a pending prediction is compared mid-cycle.
  initial begin : monitor
    exp_t e;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        act = {pc_we, hold_if_id, hold_id_ex, hold_ex_mem, flush_if_id,
               flush_id_ex, flush_ex_mem, flush_mem_wb, mem_timeout};
        n_tests++;
        if (act !== e.ctl) begin
          n_fail++;
          $display("FAIL ctl t=%0t actual=%b required=%b", $time, act, e.ctl);
        end
        n_tests++;
        if (state_o !== e.st) begin
          n_fail++;
          $display("FAIL state t=%0t actual=%0d required=%0d", $time, state_o, e.st);
        end
        n_tests++;
        if (stall_cycles !== e.cnt) begin
          n_fail++;
          $display("FAIL stall_cycles t=%0t actual=%0d required=%0d", $time, stall_cycles, e.cnt);
        end
      end
    end
  end

  initial begin : stim
    bit slow;
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    idle(2);
    // load-use bubble
    step(1, 1, 0, 0, 1, 0, 0, 0);
    idle(2);
    // three memory wait cycles, released on ready
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0, 0);
    idle(1);
    // memory never ready: abort on the 16th stall cycle
    for (int i = 0; i < 18; i++) step(1, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0, 0);
    idle(1);
    // mul/div finishing five cycles after start
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 1, 1, 1, 0);
    idle(1);
    // zero-cycle divide
    step(1, 0, 0, 0, 1, 1, 1, 0);
    idle(1);
    // branch wins over load-use
    step(1, 1, 1, 0, 1, 0, 0, 0);
    idle(1);
    // md_done arriving under a memory stall
    step(1, 0, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 0, 1, 1, 0);
    step(1, 0, 0, 1, 0, 1, 0, 0);
    step(1, 1, 0, 0, 1, 1, 0, 0);
    idle(1);
    // reset while MD_BUSY
    step(1, 0, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    idle(2);
    // perf_clr during a stall
    step(1, 1, 0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1, 0, 0, 1);
    idle(2);
    // saturation of the narrow counter
    for (int i = 0; i < 70; i++) step(1, 1, 0, 0, 1, 0, 0, 0);
    idle(1);
    // randomized traffic with occasional dead-memory phases
    slow = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) slow = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 199) != 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0,
           slow ? 1'b1 : ($urandom_range(0, 2) == 0),
           slow ? 1'b0 : ($urandom_range(0, 3) != 0),
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 49) == 0);
    end
    // let the monitor drain the queue, bounded
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    #1;
    if (sbq.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain actual=%0d pending required=0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
